// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the datapath.
// The datapath/testbench side drives run and the instruction fields.
interface multicycle_ctrl_if #(
  parameter int OPCODE_W = 6,
  parameter int FUNC_W   = 6,
  parameter int ALU_OP_W = 4,
  parameter int BR_OP_W  = 5,
  parameter int CNT_W    = 16
);
  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic [FUNC_W-1:0]   func;
  logic                ir_write;
  logic                pc_write;
  logic [1:0]          reg_write;
  logic                imm_mux_ctrl;
  logic                alu_mux_ctrl;
  logic [ALU_OP_W-1:0] alu_op;
  logic                dmem_enable;
  logic                dmem_write_enable;
  logic [1:0]          reg_write_mux_ctrl;
  logic [BR_OP_W-1:0]  br_op;
  logic                is_branch;
  logic                halted;
  logic                illegal;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    output run, opcode, func,
    input  ir_write, pc_write, reg_write,
    input  imm_mux_ctrl, alu_mux_ctrl, alu_op,
    input  dmem_enable, dmem_write_enable,
    input  reg_write_mux_ctrl, br_op, is_branch,
    input  halted, illegal, instr_count
  );

  modport slave (
    input  run, opcode, func,
    output ir_write, pc_write, reg_write,
    output imm_mux_ctrl, alu_mux_ctrl, alu_op,
    output dmem_enable, dmem_write_enable,
    output reg_write_mux_ctrl, br_op, is_branch,
    output halted, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the KGP mini-RISC datapath.
// Moore outputs decoded from state plus opcode/func latched in DECODE.
module multicycle_ctrl #(
  parameter int MEM_WAIT = 0,
  parameter int OPCODE_W = 6,
  parameter int FUNC_W   = 6,
  parameter int ALU_OP_W = 4,
  parameter int BR_OP_W  = 5,
  parameter int CNT_W    = 16
) (
  input logic             clk,
  input logic             rst,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_I    = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_HALT = '1;

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic [FUNC_W-1:0]   fn_q;
  logic [3:0]          wait_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                retire;

  logic is_r, is_i, is_ld, is_st, is_br, link;
  logic mem_last, dec_ok;

  assign is_r     = (op_q == OP_R);
  assign is_i     = (op_q == OP_I);
  assign is_ld    = (op_q == OP_LD);
  assign is_st    = (op_q == OP_ST);
  assign is_br    = (op_q == OP_BR);
  assign link     = fn_q[FUNC_W-1];
  assign mem_last = (wait_q == 4'(MEM_WAIT));
  assign dec_ok   = (bus.opcode <= OP_BR) ||
                    (bus.opcode == OP_HALT);

  assign bus.instr_count = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      fn_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= bus.opcode;
        fn_q <= bus.func;
      end
      if (state_q == S_EXEC)
        wait_q <= '0;
      else if (state_q == S_MEM)
        wait_q <= wait_q + 4'd1;
      if (retire)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d                = state_q;
    retire                 = 1'b0;
    bus.ir_write           = 1'b0;
    bus.pc_write           = 1'b0;
    bus.reg_write          = 2'b00;
    bus.imm_mux_ctrl       = 1'b0;
    bus.alu_mux_ctrl       = 1'b0;
    bus.alu_op             = '0;
    bus.dmem_enable        = 1'b0;
    bus.dmem_write_enable  = 1'b0;
    bus.reg_write_mux_ctrl = 2'b00;
    bus.br_op              = '0;
    bus.is_branch          = 1'b0;
    bus.halted             = 1'b0;
    bus.illegal            = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.ir_write = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        state_d = dec_ok ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_r, is_i: begin
            bus.alu_op       = fn_q[ALU_OP_W-1:0];
            bus.alu_mux_ctrl = is_i;
            state_d          = S_WB;
          end
          is_ld, is_st: begin
            bus.alu_mux_ctrl = 1'b1;
            bus.imm_mux_ctrl = 1'b1;
            state_d          = S_MEM;
          end
          is_br: begin
            bus.is_branch = 1'b1;
            bus.br_op     = fn_q[BR_OP_W-1:0];
            bus.pc_write  = 1'b1;
            if (link) state_d = S_WB;
            else      retire  = 1'b1;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        bus.dmem_enable       = 1'b1;
        bus.dmem_write_enable = is_st;
        bus.alu_mux_ctrl      = 1'b1;
        bus.imm_mux_ctrl      = 1'b1;
        if (mem_last) begin
          if (is_st) begin
            bus.pc_write = 1'b1;
            retire       = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        retire = 1'b1;
        unique case (1'b1)
          is_br: bus.reg_write = 2'b10;
          is_ld: begin
            bus.reg_write          = 2'b01;
            bus.reg_write_mux_ctrl = 2'b01;
            bus.pc_write           = 1'b1;
          end
          default: begin
            bus.reg_write          = 2'b01;
            bus.reg_write_mux_ctrl = 2'b10;
            bus.pc_write           = 1'b1;
          end
        endcase
      end
      S_HALT: begin
        bus.halted  = 1'b1;
        bus.illegal = (op_q != OP_HALT);
      end
      default: state_d = S_IDLE;
    endcase

    // run only matters where an instruction retires
    if (retire) state_d = bus.run ? S_FETCH : S_IDLE;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (MEM_WAIT=2, CNT_W=4).
// Directed table, hand sequences and a randomized run vs. a trace model.
module tb_multicycle_ctrl;
  localparam int MW = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CW)) bus();

  multicycle_ctrl #(.MEM_WAIT(MW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       irw;
    logic       pcw;
    logic [1:0] rw;
    logic       imm;
    logic       alum;
    logic [3:0] aop;
    logic       de;
    logic       dwe;
    logic [1:0] rwm;
    logic [4:0] bop;
    logic       br;
    logic       halt;
    logic       ill;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         cyc;
    int         n_de;
    int         n_dwe;
    out_t       ex;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   mcnt  = 0;
  out_t exp_q[$];
  vec_t tbl[9];

  function automatic out_t obs();
    out_t o;
    o.irw  = bus.ir_write;
    o.pcw  = bus.pc_write;
    o.rw   = bus.reg_write;
    o.imm  = bus.imm_mux_ctrl;
    o.alum = bus.alu_mux_ctrl;
    o.aop  = bus.alu_op;
    o.de   = bus.dmem_enable;
    o.dwe  = bus.dmem_write_enable;
    o.rwm  = bus.reg_write_mux_ctrl;
    o.bop  = bus.br_op;
    o.br   = bus.is_branch;
    o.halt = bus.halted;
    o.ill  = bus.illegal;
    return o;
  endfunction

  function automatic out_t mko(logic pcw, logic alum, logic imm,
                               logic [3:0] aop, logic br,
                               logic [4:0] bop);
    out_t o = '0;
    o.pcw  = pcw;
    o.alum = alum;
    o.imm  = imm;
    o.aop  = aop;
    o.br   = br;
    o.bop  = bop;
    return o;
  endfunction

  task automatic chk_o(string nm, out_t act, out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_v(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle outputs of one instruction, FETCH onwards
  function automatic void build(logic [5:0] op, logic [5:0] fn);
    out_t o;
    exp_q.delete();
    o = '0; o.irw = 1'b1; exp_q.push_back(o);
    o = '0; exp_q.push_back(o);
    case (op)
      6'd0, 6'd1: begin
        exp_q.push_back(mko(0, op[0], 0, fn[3:0], 0, 0));
        o = '0; o.rw = 2'b01; o.rwm = 2'b10; o.pcw = 1'b1;
        exp_q.push_back(o);
      end
      6'd2, 6'd3: begin
        exp_q.push_back(mko(0, 1, 1, 0, 0, 0));
        for (int i = 0; i <= MW; i++) begin
          o = mko(0, 1, 1, 0, 0, 0);
          o.de  = 1'b1;
          o.dwe = (op == 6'd3);
          o.pcw = (op == 6'd3) && (i == MW);
          exp_q.push_back(o);
        end
        if (op == 6'd2) begin
          o = '0; o.rw = 2'b01; o.rwm = 2'b01; o.pcw = 1'b1;
          exp_q.push_back(o);
        end
      end
      6'd4: begin
        exp_q.push_back(mko(1, 0, 0, 0, 1, fn[4:0]));
        if (fn[5]) begin
          o = '0; o.rw = 2'b10; exp_q.push_back(o);
        end
      end
      6'd63: begin
        o = '0; exp_q.push_back(o);
        o = '0; o.halt = 1'b1; exp_q.push_back(o);
      end
      default: begin
        o = '0; o.halt = 1'b1; o.ill = 1'b1;
        exp_q.push_back(o);
      end
    endcase
  endfunction

  // Precondition: DUT in FETCH. idle>0 drops run at retire.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int idle, input bit wiggle);
    int  last;
    bit  ret;
    out_t hz;
    ret = (op <= 6'd4);
    build(op, fn);
    last = exp_q.size() - 1;
    bus.opcode = op;
    bus.func   = fn;
    chk_v("cnt_at_fetch", int'(bus.instr_count), mcnt);
    for (int k = 0; k <= last; k++) begin
      if (k >= 2) begin
        bus.opcode = 6'($urandom);
        bus.func   = 6'($urandom);
      end
      if (wiggle && k < last) bus.run = 1'($urandom);
      if (k == last) bus.run = (idle == 0);
      chk_o($sformatf("op%0d_fn%0h_cyc%0d", op, fn, k), obs(), exp_q[k]);
      step();
    end
    if (ret) begin
      mcnt = (mcnt + 1) % (1 << CW);
      for (int j = 0; j < idle; j++) begin
        chk_o("idle_after_retire", obs(), '0);
        chk_v("idle_cnt", int'(bus.instr_count), mcnt);
        step();
      end
      bus.run = 1'b1;
      if (idle > 0) step();
    end else begin
      hz = exp_q[last];
      for (int j = 0; j < 3; j++) begin
        bus.run = 1'($urandom);
        chk_o("halt_sticky", obs(), hz);
        chk_v("halt_cnt", int'(bus.instr_count), mcnt);
        step();
      end
    end
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    bus.run = 1'b0;
    step();
    rst  = 1'b1;
    mcnt = 0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    out_t o;
    int   n, nde, ndwe;
    out_t ex;

    tbl[0] = '{6'd0, 6'd3,       4, 0, 0, mko(0, 0, 0, 4'h3, 0, 0)};
    tbl[1] = '{6'd1, 6'd0,       4, 0, 0, mko(0, 1, 0, 4'h0, 0, 0)};
    tbl[2] = '{6'd2, 6'h15,      7, 3, 0, mko(0, 1, 1, 4'h0, 0, 0)};
    tbl[3] = '{6'd3, 6'h2c,      6, 3, 3, mko(0, 1, 1, 4'h0, 0, 0)};
    tbl[4] = '{6'd4, 6'b000001,  3, 0, 0, mko(1, 0, 0, 4'h0, 1, 5'h01)};
    tbl[5] = '{6'd4, 6'b100001,  4, 0, 0, mko(1, 0, 0, 4'h0, 1, 5'h01)};
    tbl[6] = '{6'd0, 6'h2a,      4, 0, 0, mko(0, 0, 0, 4'ha, 0, 0)};
    tbl[7] = '{6'd1, 6'h1f,      4, 0, 0, mko(0, 1, 0, 4'hf, 0, 0)};
    tbl[8] = '{6'd4, 6'b011110,  3, 0, 0, mko(1, 0, 0, 4'h0, 1, 5'h1e)};

    rst        = 1'b0;
    bus.run    = 1'b0;
    bus.opcode = '0;
    bus.func   = '0;
    step();
    chk_o("reset_out", obs(), '0);
    chk_v("reset_cnt", int'(bus.instr_count), 0);
    rst = 1'b1;
    step();
    chk_o("idle_no_run", obs(), '0);

    // Reset in the middle of a store's memory phase
    bus.run = 1'b1;
    step();
    run_instr(6'd4, 6'd2, 0, 0);
    bus.opcode = 6'd3;
    bus.func   = 6'd0;
    step(); step(); step(); step();
    o = mko(0, 1, 1, 0, 0, 0);
    o.de = 1'b1; o.dwe = 1'b1;
    chk_o("store_mem2", obs(), o);
    chk_v("cnt_before_rst", int'(bus.instr_count), 1);
    #2 rst = 1'b0;
    #1;
    chk_o("rst_mid_mem_out", obs(), '0);
    chk_v("rst_mid_mem_cnt", int'(bus.instr_count), 0);
    #2 rst = 1'b1;
    mcnt = 0;
    step();
    o = '0; o.irw = 1'b1;
    chk_o("fetch_after_rst", obs(), o);

    // Directed table: EXEC outputs, cycle counts, dmem activity
    foreach (tbl[i]) begin
      bus.opcode = tbl[i].op;
      bus.func   = tbl[i].fn;
      n = 0; nde = 0; ndwe = 0; ex = '0;
      do begin
        o = obs();
        if (n == 2) ex = o;
        nde  += int'(o.de);
        ndwe += int'(o.dwe);
        step();
        n++;
        if (n >= 2) begin
          bus.opcode = 6'($urandom);
          bus.func   = 6'($urandom);
        end
      end while (!bus.ir_write && n < 40);
      mcnt = (mcnt + 1) % (1 << CW);
      chk_v($sformatf("tbl%0d_cycles", i), n, tbl[i].cyc);
      chk_o($sformatf("tbl%0d_exec", i), ex, tbl[i].ex);
      chk_v($sformatf("tbl%0d_de", i), nde, tbl[i].n_de);
      chk_v($sformatf("tbl%0d_dwe", i), ndwe, tbl[i].n_dwe);
      chk_v($sformatf("tbl%0d_cnt", i), int'(bus.instr_count), mcnt);
    end

    // Randomized instruction stream with run toggling
    for (int r = 0; r < 80; r++) begin
      logic [5:0] op;
      int idl;
      op  = 6'($urandom_range(0, 4));
      idl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_instr(op, 6'($urandom), idl, 1);
    end

    // run drops during an ALU op: it completes, then the core idles
    bus.opcode = 6'd0;
    bus.func   = 6'd5;
    step(); step();
    bus.run = 1'b0;
    step(); step();
    mcnt = (mcnt + 1) % (1 << CW);
    chk_o("run_drop_idle", obs(), '0);
    chk_v("run_drop_cnt", int'(bus.instr_count), mcnt);
    step();
    chk_o("run_drop_idle2", obs(), '0);
    bus.run = 1'b1;
    step();

    run_instr(6'd63, 6'd0, 0, 0);

    do_reset();
    bus.run = 1'b1;
    step();
    run_instr(6'd7, 6'd0, 0, 0);

    // 17 retires on a 4-bit counter
    do_reset();
    bus.run = 1'b1;
    step();
    for (int b = 0; b < 17; b++)
      run_instr(6'd4, 6'($urandom_range(0, 31)), 0, 0);
    chk_v("cnt_wrap", int'(bus.instr_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multi-cycle control sequencer for the KGP mini-RISC datapath. It drives the datapath control bundle automatically from the fetched instruction's opcode/func fields: `reg_write`, `imm_mux_ctrl`, `alu_mux_ctrl`, `alu_op`, `dmem_enable`, `dmem_write_enable`, `reg_write_mux_ctrl`, `br_op` and `is_branch`. Previously these signals were sequenced by hand. It adds configurable data-memory wait states, branch-and-link, halt/illegal detection, run/stop control and a retired-instruction counter.

## Interface
- `MEM_WAIT`, 0: extra cycles `dmem_enable` is held beyond the first (0..15).
- `OPCODE_W`, 6: opcode field width.
- `FUNC_W`, 6: func field width.
- `ALU_OP_W`, 4: ALU op width; must be ≤ `FUNC_W`.
- `BR_OP_W`, 5: branch op width; must be < `FUNC_W`.
- `CNT_W`, 16: retired-instruction counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `run` in 1: enables instruction fetch.
- `opcode` in `OPCODE_W`: opcode of the instruction register.
- `func` in `FUNC_W`: func field of the instruction register.
- `ir_write` out 1: load instruction register.
- `pc_write` out 1: update PC (PC+4, or branch target when `is_branch`=1).
- `reg_write` out 2: 00 none, 01 write rd, 10 write link register.
- `imm_mux_ctrl` out 1: 1 selects offset immediate (load/store).
- `alu_mux_ctrl` out 1: 1 selects immediate as ALU operand B.
- `alu_op` out `ALU_OP_W`: ALU operation.
- `dmem_enable` out 1: data memory access.
- `dmem_write_enable` out 1: data memory write.
- `reg_write_mux_ctrl` out 2: 10 ALU, 01 memory, 00 PC+4.
- `br_op` out `BR_OP_W`: branch condition.
- `is_branch` out 1: branch cycle.
- `halted` out 1: core stopped on HALT.
- `illegal` out 1: halt caused by an undefined opcode.
- `instr_count` out `CNT_W`: retired instructions.

## Operation
- States:
  - IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
  - Outputs are Moore: decoded from the state register and the opcode/func latched in DECODE only.
  - All outputs are 0 except in the states listed below.
- IDLE: when `run`=1, go to FETCH.
- FETCH: `ir_write`=1, then go to DECODE.
- DECODE: latch `opcode` and `func`, then go to EXEC.
  - Opcodes: 0 R-ALU, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, all-ones HALT.
  - Any other opcode goes to HALT with `illegal`=1.
- EXEC:
  - R-ALU: `alu_op`=func[ALU_OP_W-1:0], `alu_mux_ctrl`=0; go to WB.
  - I-ALU: same `alu_op`, `alu_mux_ctrl`=1; go to WB.
  - LOAD/STORE: `alu_op`=0 (add), `alu_mux_ctrl`=1, `imm_mux_ctrl`=1; go to MEM.
  - BRANCH: `is_branch`=1, `br_op`=func[BR_OP_W-1:0], `pc_write`=1.
    - func[FUNC_W-1]=1 (link): go to WB.
    - Otherwise: retire and go to FETCH.
  - HALT opcode: go to HALT.
- MEM:
  - Outputs: `dmem_enable`=1, `dmem_write_enable`=1 for STORE, address controls held as in EXEC.
  - Wait counter cleared on entry; stay in MEM for exactly MEM_WAIT+1 cycles.
  - Exit to WB for LOAD; for STORE, `pc_write`=1 on the last cycle, retire, go to FETCH.
- WB:
  - ALU ops: `reg_write`=01, `reg_write_mux_ctrl`=10, `pc_write`=1.
  - LOAD: `reg_write`=01, `reg_write_mux_ctrl`=01, `pc_write`=1.
  - Link: `reg_write`=10, `reg_write_mux_ctrl`=00, `pc_write`=0 (PC already written in EXEC).
  - Retire, then go to FETCH.
- Run control: `run` is sampled only at the retire point and in IDLE. `run`=0 at retire goes to IDLE. An instruction in flight always completes.
- HALT: `halted`=1, sticky; only `rst` exits.
- `instr_count`: +1 on each retire; HALT and illegal opcodes are not counted. Wraps modulo 2^CNT_W.

## Timing
- Reset: asynchronous assert with `rst`=0. Forces IDLE, counters/latches 0, all outputs 0. Deassertion is synchronous in effect: the first FETCH occurs at the edge after `rst`=1 with `run`=1.
- Cycles per instruction: ALU 4; branch 3; branch-and-link 4; STORE 4+MEM_WAIT; LOAD 5+MEM_WAIT; HALT 3 to reach HALT.
- Retire cycle: `instr_count` updates at the clock edge ending that cycle. Next FETCH follows immediately when `run`=1.
- `rst` asserted mid-MEM: `dmem_enable`/`dmem_write_enable` drop immediately (asynchronously).
- `opcode`/`func` may change after DECODE without effect.

## Test plan
- **Reset mid-MEM:** MEM_WAIT=2, `run`=1, STORE, `rst` pulsed low in MEM cycle 2. Required: state=IDLE, `dmem_*`=0 and `instr_count`=0 immediately; clean FETCH after release.
- **ALU sequence:** xor R (opcode 0, func 3) then addi I (opcode 1, func 0). Required: `alu_op`=3 with `alu_mux_ctrl`=0, then `alu_op`=0 with `alu_mux_ctrl`=1. WB shows `reg_write`=01, mux=10. `instr_count`=2 after 8 cycles.
- **Memory wait states:** MEM_WAIT=2, LOAD then STORE. Required: `dmem_enable` high exactly 3 cycles each; `dmem_write_enable` only during STORE. Load WB has mux=01. Total 7+6=13 cycles.
- **Branch and branch-and-link:** BRANCH func=6'b000001, then func=6'b100001. Required: `is_branch`=1, `br_op`=1, `pc_write`=1 in EXEC. First returns to FETCH (3 cycles). Second adds WB with `reg_write`=10, mux=00, `pc_write`=0.
- **Run drop, halt and illegal:** `run` drops mid-ALU: instruction completes, controller idles, `instr_count` increments once. Then HALT: `halted`=1, `illegal`=0, count unchanged. After reset, opcode 7: `halted`=1, `illegal`=1.
- **Counter wrap:** CNT_W=4, 17 branches. Required: `instr_count`=1.
